// File: rtl/rd53_weight_enum.sv
`default_nettype none
// ============================================================================
// Module      : rd53_weight_enum
// Description : Streams every N-bit vector whose popcount equals a requested
//               weight k, in ascending numeric order, one vector per beat over
//               a valid/ready stream. Requests with k > N produce a single
//               error beat. Sequential inverse of the rd53 weight counter.
//               Optional self-checker enabled by defining RD53_ENUM_CHECK_EN
//               (adds the chk_err port).
// Revision    : 1.0 - initial release
// ============================================================================
module rd53_weight_enum #(
    parameter  int N  = 5,
    localparam int WW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [WW-1:0] req_weight,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_vec,
    output logic [N-1:0]  out_idx,
    output logic          out_last,
`ifdef RD53_ENUM_CHECK_EN
    output logic          chk_err,
`endif
    output logic          out_err
);

    localparam logic [N-1:0]  c_all_ones = '1;
    localparam logic [WW-1:0] c_max_k    = WW'(N);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [WW-1:0] r_k;
    logic [N-1:0]  r_vec;
    logic [N-1:0]  r_idx;
    logic          r_valid;
    logic          r_last;
    logic          r_err;

    logic          w_accept;
    logic          w_beat;
    logic          w_req_illegal;
    logic          w_req_single;
    logic [N-1:0]  w_first_vec;
    logic [N-1:0]  w_req_max_vec;
    logic [N-1:0]  w_cur_max_vec;
    logic [WW-1:0] w_tz;
    logic [N-1:0]  w_ripple;
    logic [N-1:0]  w_tail;
    logic [N-1:0]  w_next_vec;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus request/beat handshake strobes
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        w_accept    = 1'b0;
        w_beat      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (r_valid && out_ready) begin
                    w_beat = 1'b1;
                    if (r_last) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request decode: first vector is k ones at the LSB end, the last is k
    // ones at the MSB end; they coincide only for k=0 and k=N
    always_comb begin
        w_req_illegal = (req_weight > c_max_k);
        w_first_vec   = ~(c_all_ones << req_weight);
        w_req_max_vec = ~(c_all_ones >> req_weight);
        w_req_single  = (w_first_vec == w_req_max_vec);
        w_cur_max_vec = ~(c_all_ones >> r_k);
    end

    // Next same-popcount successor (Gosper): add the lowest set bit to ripple
    // the low run of ones up by one place, then refill the remainder at the
    // LSB end. Division by the lowest set bit is a right shift by its index.
    // The result is only consumed when the current vector is not the last.
    always_comb begin
        w_tz = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (r_vec[i]) begin
                w_tz = WW'(i);
            end
        end
        w_ripple   = r_vec + (N'(1) << w_tz);
        w_tail     = ((w_ripple ^ r_vec) >> 2) >> w_tz;
        w_next_vec = w_ripple | w_tail;
    end

    // Output beat registers: load on acceptance, advance on each transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k     <= '0;
            r_vec   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_k     <= req_weight;
            r_valid <= 1'b1;
            r_idx   <= '0;
            r_err   <= w_req_illegal;
            r_vec   <= w_req_illegal ? '0 : w_first_vec;
            r_last  <= w_req_illegal | w_req_single;
        end else if (w_beat) begin
            if (r_last) begin
                r_valid <= 1'b0;
            end else begin
                r_vec  <= w_next_vec;
                r_idx  <= r_idx + N'(1);
                r_last <= (w_next_vec == w_cur_max_vec);
            end
        end
    end

    assign out_valid = r_valid;
    assign out_vec   = r_vec;
    assign out_idx   = r_idx;
    assign out_last  = r_last;
    assign out_err   = r_err;

`ifdef RD53_ENUM_CHECK_EN
    logic [WW-1:0] w_popcount;
    logic [N-1:0]  r_prev_vec;
    logic          r_have_prev;
    logic          r_chk_err;

    // Forward rd53 function: popcount of the vector being presented
    always_comb begin
        w_popcount = '0;
        for (int i = 0; i < N; i++) begin
            w_popcount = w_popcount + WW'(r_vec[i]);
        end
    end

    // Sticky checker: wrong weight or non-increasing order within a burst
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_vec  <= '0;
            r_have_prev <= 1'b0;
            r_chk_err   <= 1'b0;
        end else if (w_accept) begin
            r_have_prev <= 1'b0;
        end else if (w_beat) begin
            if (!r_err && (w_popcount != r_k)) begin
                r_chk_err <= 1'b1;
            end
            if (r_have_prev && (r_vec <= r_prev_vec)) begin
                r_chk_err <= 1'b1;
            end
            r_prev_vec  <= r_vec;
            r_have_prev <= ~r_last;
        end
    end

    assign chk_err = r_chk_err;
`endif

endmodule
`default_nettype wire
